player_ball_collider_unit: RTL and testbench

// - Detects contact between the ball and one circular player, and returns the ball's post-collision position and direction.
// - Sits between the ball controller and each player; the controller instantiates one per player.
// - If the ball is not touching the player, position and direction pass through unchanged.
// - Fully pipelined with a fixed 2-cycle latency; accepts a new sample every cycle.

---
 rtl/player_ball_collider_unit.sv | 141 ++++++++++++++
 tb/tb_player_ball_collider_unit.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/player_ball_collider_unit.sv
// Two-stage ball/player contact resolver: stage 1 takes centre deltas, stage 2
// squares them, tests contact and pushes the ball out along the hit axes.
module player_ball_collider_unit #(
  parameter int PLAYER_RADIUS = 16,
  parameter int BALL_RADIUS   = 8,
  parameter int PUSH          = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [18:0] old_ball_x,
  input  logic [18:0] old_ball_y,
  input  logic [18:0] player_x,
  input  logic [18:0] player_y,
  input  logic [18:0] old_ball_dir_x,
  input  logic [18:0] old_ball_dir_y,
  output logic        out_valid,
  output logic        hit,
  output logic [18:0] new_ball_x,
  output logic [18:0] new_ball_y,
  output logic [18:0] new_ball_dir_x,
  output logic [18:0] new_ball_dir_y
);

  localparam int          CONTACT = PLAYER_RADIUS + BALL_RADIUS + 2;
  localparam logic [37:0] THRESH  = 38'(CONTACT * CONTACT);
  localparam logic [18:0] PUSH_V  = 19'(PUSH);

  // Stage 1 state
  logic        s1_valid_q, s1_valid_d;
  logic [18:0] s1_adx_q, s1_adx_d;
  logic [18:0] s1_ady_q, s1_ady_d;
  logic        s1_negx_q, s1_negx_d;
  logic        s1_negy_q, s1_negy_d;
  logic [18:0] s1_x_q, s1_x_d;
  logic [18:0] s1_y_q, s1_y_d;
  logic [18:0] s1_vx_q, s1_vx_d;
  logic [18:0] s1_vy_q, s1_vy_d;

  // Stage 2 (output) state
  logic        out_valid_q, out_valid_d;
  logic        hit_q, hit_d;
  logic [18:0] x_q, x_d;
  logic [18:0] y_q, y_d;
  logic [18:0] vx_q, vx_d;
  logic [18:0] vy_q, vy_d;

  logic [18:0] dx, dy;
  logic [37:0] d2;
  logic        horiz, vert, aff_x, aff_y;

  // Escape velocity: keep magnitude, never zero, point away from the player.
  function automatic logic [18:0] resolve_dir(input logic [18:0] dir, input logic neg);
    logic [18:0] mag;
    mag = dir[18] ? 19'(-dir) : dir;
    if (mag == 19'd0) mag = 19'd1;
    return neg ? 19'(-mag) : mag;
  endfunction

  always_comb begin
    dx         = old_ball_x - player_x;
    dy         = old_ball_y - player_y;
    s1_valid_d = in_valid;
    s1_negx_d  = dx[18];
    s1_negy_d  = dy[18];
    s1_adx_d   = dx[18] ? 19'(-dx) : dx;
    s1_ady_d   = dy[18] ? 19'(-dy) : dy;
    s1_x_d     = old_ball_x;
    s1_y_d     = old_ball_y;
    s1_vx_d    = old_ball_dir_x;
    s1_vy_d    = old_ball_dir_y;
  end

  always_comb begin
    d2    = ({19'd0, s1_adx_q} * {19'd0, s1_adx_q}) + ({19'd0, s1_ady_q} * {19'd0, s1_ady_q});
    hit_d = d2 < THRESH;
    horiz = {1'b0, s1_adx_q} > {s1_ady_q, 1'b0};
    vert  = {1'b0, s1_ady_q} > {s1_adx_q, 1'b0};
    // Diagonal is "neither dominant", so each axis is hit unless the other dominates.
    aff_x = hit_d && !vert;
    aff_y = hit_d && !horiz;

    out_valid_d = s1_valid_q;
    x_d  = s1_x_q;
    y_d  = s1_y_q;
    vx_d = s1_vx_q;
    vy_d = s1_vy_q;
    if (aff_x) begin
      x_d  = s1_negx_q ? (s1_x_q - PUSH_V) : (s1_x_q + PUSH_V);
      vx_d = resolve_dir(s1_vx_q, s1_negx_q);
    end
    if (aff_y) begin
      y_d  = s1_negy_q ? (s1_y_q - PUSH_V) : (s1_y_q + PUSH_V);
      vy_d = resolve_dir(s1_vy_q, s1_negy_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_adx_q    <= '0;
      s1_ady_q    <= '0;
      s1_negx_q   <= 1'b0;
      s1_negy_q   <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_vx_q     <= '0;
      s1_vy_q     <= '0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      vx_q        <= '0;
      vy_q        <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_adx_q    <= s1_adx_d;
      s1_ady_q    <= s1_ady_d;
      s1_negx_q   <= s1_negx_d;
      s1_negy_q   <= s1_negy_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_vx_q     <= s1_vx_d;
      s1_vy_q     <= s1_vy_d;
      out_valid_q <= out_valid_d;
      hit_q       <= hit_d;
      x_q         <= x_d;
      y_q         <= y_d;
      vx_q        <= vx_d;
      vy_q        <= vy_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign hit            = hit_q;
  assign new_ball_x     = x_q;
  assign new_ball_y     = y_q;
  assign new_ball_dir_x = vx_q;
  assign new_ball_dir_y = vy_q;

endmodule

// File: tb/tb_player_ball_collider_unit.sv
// Scoreboard bench: the driver queues hand-computed results, the monitor checks
// each out_valid against the head of the queue, including its arrival cycle.
module tb_player_ball_collider_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] old_ball_x = '0, old_ball_y = '0;
  logic [18:0] player_x = 19'd240, player_y = 19'd300;
  logic [18:0] old_ball_dir_x = '0, old_ball_dir_y = '0;
  logic        out_valid, hit;
  logic [18:0] new_ball_x, new_ball_y, new_ball_dir_x, new_ball_dir_y;

  typedef struct packed {
    logic        hit;
    logic [18:0] x, y, vx, vy;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   txn = 0;

  player_ball_collider_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .old_ball_x(old_ball_x), .old_ball_y(old_ball_y),
    .player_x(player_x), .player_y(player_y),
    .old_ball_dir_x(old_ball_dir_x), .old_ball_dir_y(old_ball_dir_y),
    .out_valid(out_valid), .hit(hit),
    .new_ball_x(new_ball_x), .new_ball_y(new_ball_y),
    .new_ball_dir_x(new_ball_dir_x), .new_ball_dir_y(new_ball_dir_y)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int s19(input logic [18:0] v);
    return int'($signed(v));
  endfunction

  // One sample per call; consecutive calls give back-to-back in_valid.
  task automatic send(input int bx, input int by, input int vx, input int vy,
                      input logic eh, input int ex, input int ey, input int evx, input int evy);
    exp_t e;
    @(posedge clk); #1;
    in_valid       = 1'b1;
    old_ball_x     = 19'(bx);
    old_ball_y     = 19'(by);
    old_ball_dir_x = 19'(vx);
    old_ball_dir_y = 19'(vy);
    e.hit = eh; e.x = 19'(ex); e.y = 19'(ey); e.vx = 19'(evx); e.vy = 19'(evy);
    e.cyc = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " out_valid"}, int'(out_valid), 0);
    chk({tag, " hit"}, int'(hit), 0);
    chk({tag, " x"}, s19(new_ball_x), 0);
    chk({tag, " y"}, s19(new_ball_y), 0);
    chk({tag, " dir_x"}, s19(new_ball_dir_x), 0);
    chk({tag, " dir_y"}, s19(new_ball_dir_y), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_output: got out_valid=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        txn++;
        $display("[TB] txn %0d cyc %0d hit=%0d pos=(%0d,%0d) dir=(%0d,%0d)", txn, cyc, hit,
                 s19(new_ball_x), s19(new_ball_y), s19(new_ball_dir_x), s19(new_ball_dir_y));
        chk("latency", cyc, e.cyc);
        chk("hit", int'(hit), int'(e.hit));
        chk("new_x", s19(new_ball_x), s19(e.x));
        chk("new_y", s19(new_ball_y), s19(e.y));
        chk("new_dir_x", s19(new_ball_dir_x), s19(e.vx));
        chk("new_dir_y", s19(new_ball_dir_y), s19(e.vy));
      end
    end
  end

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    idle();

    // Player (240,300), contact threshold 26^2 = 676
    send(262, 300, -2,  1, 1'b1, 266, 300,  2,  1);   // horizontal
    idle();
    send(240, 280,  1,  2, 1'b1, 240, 276,  1, -2);   // vertical, pushed up
    send(255, 315, -3, -3, 1'b1, 259, 319,  3,  3);   // diagonal, d2=450
    send(266, 300,  7, -5, 1'b0, 266, 300,  7, -5);   // d2=676: no hit
    send(262, 300,  0,  2, 1'b1, 266, 300,  1,  2);   // zero dir becomes 1
    send(218, 300,  3,  0, 1'b1, 214, 300, -3,  0);   // horizontal from the left
    send(225, 285,  1,  1, 1'b1, 221, 281, -1, -1);   // diagonal from upper-left
    send(240, 300,  0,  0, 1'b1, 244, 304,  1,  1);   // exact overlap
    send(262, 300,  5,  0, 1'b1, 266, 300,  5,  0);   // already receding
    idle();
    // Back-to-back miss, hit, miss
    send(400, 100,  2,  3, 1'b0, 400, 100,  2,  3);
    send(240, 322, -1, -4, 1'b1, 240, 326, -1,  4);
    send( 10,  20, -6,  1, 1'b0,  10,  20, -6,  1);
    idle();

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("drain_pending", exp_q.size(), 0);

    // Reset with a sample sitting in stage 1
    send(262, 300, -2, 1, 1'b1, 266, 300, 2, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_zero("inflight_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_late_output", int'(out_valid), 0);
    end

    // Pipeline must still work after the mid-flight reset
    send(240, 280, 1, 2, 1'b1, 240, 276, 1, -2);
    idle();
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    chk("final_pending", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
